systolic_seq_ctrl: RTL and testbench

Sequencer for one N×M systolic MAC tile. It accepts a start handshake with a reduction length K and clears the accumulators. It then streams K operand beats with per-row and per-column skew enables, drains the array pipeline, and writes the N result rows out under back-pressure. It sits between the host/DMA command interface and the MAC array plus its A/B operand buffers and C result memory.

---
 rtl/systolic_seq_if.sv | 42 ++++
 rtl/systolic_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_if.sv
// systolic_seq_if
// Command / array-control bundle of the systolic tile sequencer.
//   start, k_len  : host command (tile request and reduction length K)
//   c_ready       : C result memory accepts the current row write
//   busy, done    : sequencer status, done is a one-cycle completion pulse
//   acc_clr       : clear all PE accumulators
//   a_rd_en/b_rd_en : operand buffer beat reads
//   a_row_en/b_col_en : skewed per-row / per-column valids into the array
//   c_wr_en, c_row_sel : C row write valid and one-hot row select
// Modports:
//   master : the sequencer (drives control/status, samples command and c_ready)
//   slave  : host, operand buffers and C memory
interface systolic_seq_if #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int KW = 8
);
  logic          start;
  logic [KW-1:0] k_len;
  logic          c_ready;
  logic          busy;
  logic          done;
  logic          acc_clr;
  logic          a_rd_en;
  logic          b_rd_en;
  logic [N-1:0]  a_row_en;
  logic [M-1:0]  b_col_en;
  logic          c_wr_en;
  logic [N-1:0]  c_row_sel;

  modport master (
    input  start, k_len, c_ready,
    output busy, done, acc_clr, a_rd_en, b_rd_en,
           a_row_en, b_col_en, c_wr_en, c_row_sel
  );

  modport slave (
    output start, k_len, c_ready,
    input  busy, done, acc_clr, a_rd_en, b_rd_en,
           a_row_en, b_col_en, c_wr_en, c_row_sel
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl
// Sequencer for one N x M systolic MAC tile: accepts a start with reduction
// length K, clears the accumulators, streams K operand beats with row/column
// skew, drains the array pipeline (N+M-1 cycles) and writes the N result rows
// under c_ready back-pressure, then pulses done.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset
//   bus          : systolic_seq_if.master (command, status, array control)
//   perf_cycles  : busy-cycle counter, only when SEQ_CTRL_PERF_EN is defined
// Optional feature macro: SEQ_CTRL_PERF_EN
// All outputs are registered or decoded from registered state only.
module systolic_seq_ctrl #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int KW = 8
) (
  input  logic             clk,
  input  logic             rst,
  systolic_seq_if.master   bus
`ifdef SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int            RW         = $clog2(N);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(N + M - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] r_q, r_d;
  logic [N-2:0]  a_skew_q, a_skew_d;
  logic [M-2:0]  b_skew_q, b_skew_d;

  logic          feed;
  logic [N-1:0]  a_row_en_w;
  logic [M-1:0]  b_col_en_w;

  // Lane 0 is the FEED decode; higher lanes are its delayed copies, so the
  // skew tails drain naturally once FEED ends.
  assign feed       = (state_q == S_FEED);
  assign a_row_en_w = {a_skew_q, feed};
  assign b_col_en_w = {b_skew_q, feed};

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    a_skew_d = a_row_en_w[N-2:0];
    b_skew_d = b_col_en_w[M-2:0];
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.k_len != '0) begin
            k_d     = bus.k_len;
            cnt_d   = '0;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        // Compare against K-1 so K = 2^KW-1 ends without the counter wrapping.
        if (cnt_q == (k_q - KW'(1))) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          r_d     = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_WRITE: begin
        if (bus.c_ready) begin
          if (r_q == ROW_LAST) begin
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      a_skew_q <= '0;
      b_skew_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      a_skew_q <= a_skew_d;
      b_skew_q <= b_skew_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.acc_clr   = (state_q == S_CLEAR);
  assign bus.a_rd_en   = feed;
  assign bus.b_rd_en   = feed;
  assign bus.a_row_en  = a_row_en_w;
  assign bus.b_col_en  = b_col_en_w;
  assign bus.c_wr_en   = (state_q == S_WRITE);
  assign bus.c_row_sel = (state_q == S_WRITE) ? (N'(1) << r_q) : '0;

`ifdef SEQ_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Counts busy cycles of the last accepted operation, saturating.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        perf_d = '0;
      end
    end else if (perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl
// Directed bench for systolic_seq_ctrl: one 2x2 and one 4x3 instance, a
// per-cycle timing model of the output schedule and a row-write scoreboard.
module tb_systolic_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v;
  logic [7:0] k_v;
  logic       rdy_v;
  int         sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_seq_if #(.N(2), .M(2), .KW(8)) if0 ();
  systolic_seq_if #(.N(4), .M(3), .KW(8)) if1 ();

  assign if0.start   = start_v && (sel == 0);
  assign if0.k_len   = k_v;
  assign if0.c_ready = rdy_v;
  assign if1.start   = start_v && (sel != 0);
  assign if1.k_len   = k_v;
  assign if1.c_ready = rdy_v;

`ifdef SEQ_CTRL_PERF_EN
  logic [31:0] perf0, perf1;
`endif

  systolic_seq_ctrl #(.N(2), .M(2), .KW(8)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(if0)
`ifdef SEQ_CTRL_PERF_EN
    , .perf_cycles(perf0)
`endif
  );

  systolic_seq_ctrl #(.N(4), .M(3), .KW(8)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(if1)
`ifdef SEQ_CTRL_PERF_EN
    , .perf_cycles(perf1)
`endif
  );

  // {busy, done, acc_clr, a_rd, b_rd, c_wr, a_row_en[3:0], b_col_en[3:0], c_row_sel[3:0]}
  logic [17:0] obs0, obs1, obs;
  assign obs0 = {if0.busy, if0.done, if0.acc_clr, if0.a_rd_en, if0.b_rd_en, if0.c_wr_en,
                 2'b00, if0.a_row_en, 2'b00, if0.b_col_en, 2'b00, if0.c_row_sel};
  assign obs1 = {if1.busy, if1.done, if1.acc_clr, if1.a_rd_en, if1.b_rd_en, if1.c_wr_en,
                 if1.a_row_en, 1'b0, if1.b_col_en, if1.c_row_sel};
  assign obs  = (sel != 0) ? obs1 : obs0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // s: instance, k: K, stall: c_ready=0 cycles on row 0,
  // rst_c: cycle to assert rst (-1 none), alt_c: cycle to re-pulse start (-1 none)
  task automatic run(input int s, input int k, input int stall, input int rst_c, input int alt_c);
    int          n, m, w0, wr, stl, done_c, rd_cnt, exp_row, finished;
    logic [3:0]  re, ce, rs;
    logic        acc, rd, in_wr, dn, bsy;
    logic [17:0] e;
    int          q[$];
    n = (s != 0) ? 4 : 2;
    m = (s != 0) ? 3 : 2;
    sel = s;
    rdy_v = 1'b1;
    k_v = 8'(k);
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    q.delete();
    if (k != 0) for (int r = 0; r < n; r++) q.push_back(r);
    w0 = k + n + m + 1;
    wr = 0;
    stl = stall;
    done_c = (k == 0) ? 1 : -1;
    rd_cnt = 0;
    finished = 0;
    for (int c = 1; c <= 600 && finished == 0; c++) begin
      in_wr = (k != 0) && (c >= w0) && (wr < n);
      rdy_v = 1'b1;
      if (in_wr && stl > 0) begin
        rdy_v = 1'b0;
        stl--;
      end
      if (c == alt_c) begin
        start_v = 1'b1;
        k_v = 8'(k + 5);
      end else begin
        start_v = 1'b0;
        k_v = 8'(k);
      end
      if (c == rst_c) rst = 1'b1;
      acc = (k != 0) && (c == 1);
      rd  = (k != 0) && (c >= 2) && (c <= k + 1);
      re = '0;
      ce = '0;
      for (int i = 0; i < n; i++) re[i] = (k != 0) && (c >= 2 + i) && (c <= k + 1 + i);
      for (int j = 0; j < m; j++) ce[j] = (k != 0) && (c >= 2 + j) && (c <= k + 1 + j);
      rs  = in_wr ? 4'(1 << wr) : 4'h0;
      dn  = (c == done_c);
      bsy = (done_c < 0) || (c <= done_c);
      e = {bsy, dn, acc, rd, rd, in_wr, re, ce, rs};
      check("cycle_outputs", 32'(obs), 32'(e));
      if (obs[14]) rd_cnt++;
      if (obs[12] && rdy_v) begin
        if (q.size() == 0) begin
          check("unexpected_write", 32'(obs[3:0]), 32'h0);
        end else begin
          exp_row = q.pop_front();
          check("row_sel", 32'(obs[3:0]), 32'(1 << exp_row));
        end
      end
      if (in_wr && rdy_v) begin
        wr++;
        if (wr == n) done_c = c + 1;
      end
      if (c == rst_c) begin
        tick();
        rst = 1'b0;
        check("rst_outputs", 32'(obs), 32'h0);
        for (int t = 0; t < 4; t++) begin
          tick();
          check("rst_idle", 32'(obs), 32'h0);
        end
        finished = 1;
      end else if (c == done_c) begin
        tick();
        check("idle_after_done", 32'(obs), 32'h0);
        check("rd_count", rd_cnt, k);
        check("sb_empty", q.size(), 0);
`ifdef SEQ_CTRL_PERF_EN
        check("perf_cycles", (s != 0) ? perf1 : perf0, done_c);
`endif
        finished = 1;
      end else begin
        tick();
      end
    end
    check("terminated", finished, 1);
  endtask

  initial begin
    rst = 1'b1;
    start_v = 1'b0;
    k_v = 8'd0;
    rdy_v = 1'b1;
    sel = 0;
    repeat (3) tick();
    check("reset_dut0", 32'(obs0), 32'h0);
    check("reset_dut1", 32'(obs1), 32'h0);
`ifdef SEQ_CTRL_PERF_EN
    check("reset_perf0", perf0, 32'h0);
`endif
    rst = 1'b0;
    tick();
    check("idle_no_start", 32'(obs0), 32'h0);

    run(0, 4, 0, -1, -1);    // basic K=4
    run(0, 4, 3, -1, -1);    // back-pressure on row 0
    run(0, 0, 0, -1, -1);    // K=0 goes straight to DONE
    run(0, 4, 0, -1, 3);     // start during FEED ignored
    run(0, 4, 0, 7, -1);     // reset during DRAIN
    run(0, 4, 0, -1, -1);    // full sequence after reset abort
    run(0, 1, 1, -1, -1);    // K=1 with one stall
    run(1, 255, 0, -1, -1);  // 4x3, K=2^KW-1
    run(1, 3, 2, -1, -1);    // 4x3, short K, stalls

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
